// File: rtl/bp_pkg.sv
// Shared helpers for the gshare predictor: counter init/saturation math
// and the taken/not-taken encodings.
package bp_pkg;

    localparam logic BP_TAKEN     = 1'b1;
    localparam logic BP_NOT_TAKEN = 1'b0;

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic logic [31:0] bp_ctr_init(input int ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    // Increment, holding at the all-ones value for a ctr_w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int ctr_w);
        logic [31:0] max_v;
        max_v = (32'd1 << ctr_w) - 32'd1;
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

    // Decrement, holding at zero.
    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2**HIST_W saturating counters with one
// combinational read port and one synchronous train port.
module bp_pht
    import bp_pkg::*;
#(
    parameter int HIST_W = 6,
    parameter int CTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HIST_W-1:0] rd_idx,
    output logic [CTR_W-1:0]  rd_ctr,
    input  logic              train_en,
    input  logic [HIST_W-1:0] train_idx,
    input  logic              train_taken
);

    localparam int DEPTH = 2 ** HIST_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(bp_ctr_init(CTR_W));

    logic [CTR_W-1:0] pht [DEPTH];

    // Read sees the pre-train value of the entry; there is no bypass.
    assign rd_ctr = pht[rd_idx];

    // Train one counter per cycle; reset reloads every entry.
    // NOTE: sequential state uses <= so every read in this edge sees the
    // old value; the array is a register file (not a RAM macro), so
    // resetting each entry here is legal and is what the predictor needs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else if (train_en) begin
            if (train_taken == BP_TAKEN) begin
                pht[train_idx] <= CTR_W'(sat_inc(32'(pht[train_idx]), CTR_W));
            end else begin
                pht[train_idx] <= CTR_W'(sat_dec(32'(pht[train_idx])));
            end
        end
    end

endmodule

// File: rtl/bp_gshare_ckpt.sv
// Gshare direction predictor for the fetch stage. Holds the speculative
// global history, its checkpoint-based recovery, and perf counters.
module bp_gshare_ckpt
    import bp_pkg::*;
#(
    parameter int HIST_W  = 6,
    parameter int CTR_W   = 2,
    parameter int EIP_LSB = 0,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       eip,
    input  logic              is_BR,
    input  logic              LD,
    input  logic              prev_is_BR,
    input  logic              prev_BR_result,
    input  logic [HIST_W-1:0] prev_BR_alias,
    input  logic [HIST_W-1:0] prev_BR_ghr,
    input  logic              prev_BR_mispred,
    output logic              prediction,
    output logic [HIST_W-1:0] BP_alias,
    output logic [HIST_W-1:0] GBHR,
    output logic [PERF_W-1:0] perf_br,
    output logic [PERF_W-1:0] perf_mispred
);

    logic [HIST_W-1:0] ghr_q;
    logic [HIST_W-1:0] ghr_d;
    logic [CTR_W-1:0]  rd_ctr;
    logic [PERF_W-1:0] perf_br_q;
    logic [PERF_W-1:0] perf_mispred_q;
    logic              recover;

    // Only a slice of eip and the low history bits of the checkpoint
    // feed the logic; fold the rest here so they read as intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{eip, prev_BR_ghr[HIST_W-1]};

    assign BP_alias     = eip[EIP_LSB +: HIST_W] ^ ghr_q;
    assign prediction   = rd_ctr[CTR_W-1] ? BP_TAKEN : BP_NOT_TAKEN;
    assign GBHR         = ghr_q;
    assign perf_br      = perf_br_q;
    assign perf_mispred = perf_mispred_q;

    // A mispredict flag is meaningful only alongside a resolved branch.
    assign recover = prev_is_BR & prev_BR_mispred;

    bp_pht #(
        .HIST_W (HIST_W),
        .CTR_W  (CTR_W)
    ) u_pht (
        .clk         (clk),
        .reset       (reset),
        .rd_idx      (BP_alias),
        .rd_ctr      (rd_ctr),
        .train_en    (prev_is_BR),
        .train_idx   (prev_BR_alias),
        .train_taken (prev_BR_result)
    );

    // History next-state: checkpoint recovery beats speculative shift.
    // NOTE: ghr_d gets a default before the if-chain so every path assigns
    // it and no latch is inferred.
    always_comb begin
        ghr_d = ghr_q;
        if (recover) begin
            ghr_d = {prev_BR_ghr[HIST_W-2:0], prev_BR_result};
        end else if (LD && is_BR) begin
            ghr_d = {ghr_q[HIST_W-2:0], prediction};
        end
    end

    // History register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Saturating perf counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_br_q      <= '0;
            perf_mispred_q <= '0;
        end else begin
            if (prev_is_BR && (perf_br_q != '1)) begin
                perf_br_q <= perf_br_q + PERF_W'(1);
            end
            if (recover && (perf_mispred_q != '1)) begin
                perf_mispred_q <= perf_mispred_q + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bp_gshare_ckpt.sv
// Self-checking bench for bp_gshare_ckpt: a directed vector table plus
// hand-written sequences for counter saturation and mid-stream reset.
module tb_bp_gshare_ckpt;

    localparam int HIST_W = 6;
    localparam int CTR_W  = 2;
    localparam int PERF_W = 16;
    localparam int SAT_W  = 4;
    localparam logic [31:0] E = 32'h12345678;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       eip;
    logic              is_BR;
    logic              LD;
    logic              prev_is_BR;
    logic              prev_BR_result;
    logic [HIST_W-1:0] prev_BR_alias;
    logic [HIST_W-1:0] prev_BR_ghr;
    logic              prev_BR_mispred;

    logic              prediction;
    logic [HIST_W-1:0] BP_alias;
    logic [HIST_W-1:0] GBHR;
    logic [PERF_W-1:0] perf_br;
    logic [PERF_W-1:0] perf_mispred;

    logic              s_prediction;
    logic [HIST_W-1:0] s_alias;
    logic [HIST_W-1:0] s_ghr;
    logic [SAT_W-1:0]  s_perf_br;
    logic [SAT_W-1:0]  s_perf_mispred;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bp_gshare_ckpt #(
        .HIST_W (HIST_W), .CTR_W (CTR_W), .EIP_LSB (0), .PERF_W (PERF_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .eip             (eip),
        .is_BR           (is_BR),
        .LD              (LD),
        .prev_is_BR      (prev_is_BR),
        .prev_BR_result  (prev_BR_result),
        .prev_BR_alias   (prev_BR_alias),
        .prev_BR_ghr     (prev_BR_ghr),
        .prev_BR_mispred (prev_BR_mispred),
        .prediction      (prediction),
        .BP_alias        (BP_alias),
        .GBHR            (GBHR),
        .perf_br         (perf_br),
        .perf_mispred    (perf_mispred)
    );

    // Narrow perf counters so saturation is reachable in a few cycles.
    bp_gshare_ckpt #(
        .HIST_W (HIST_W), .CTR_W (CTR_W), .EIP_LSB (0), .PERF_W (SAT_W)
    ) dut_sat (
        .clk             (clk),
        .reset           (reset),
        .eip             (eip),
        .is_BR           (is_BR),
        .LD              (LD),
        .prev_is_BR      (prev_is_BR),
        .prev_BR_result  (prev_BR_result),
        .prev_BR_alias   (prev_BR_alias),
        .prev_BR_ghr     (prev_BR_ghr),
        .prev_BR_mispred (prev_BR_mispred),
        .prediction      (s_prediction),
        .BP_alias        (s_alias),
        .GBHR            (s_ghr),
        .perf_br         (s_perf_br),
        .perf_mispred    (s_perf_mispred)
    );

    typedef struct {
        logic [31:0] eip;
        logic        is_br;
        logic        ld;
        logic        p_br;
        logic        p_res;
        logic [5:0]  p_alias;
        logic [5:0]  p_ghr;
        logic        p_mis;
        logic        exp_pred;   // before the edge
        logic [5:0]  exp_alias;  // before the edge
        logic [5:0]  exp_ghr;    // after the edge
        logic [15:0] exp_br;     // after the edge
        logic [15:0] exp_mis;    // after the edge
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] e, input logic ib, input logic ld,
                         input logic pb, input logic pr, input logic [5:0] pa,
                         input logic [5:0] pg, input logic pm);
        eip             = e;
        is_BR           = ib;
        LD              = ld;
        prev_is_BR      = pb;
        prev_BR_result  = pr;
        prev_BR_alias   = pa;
        prev_BR_ghr     = pg;
        prev_BR_mispred = pm;
    endtask

    function automatic logic [31:0] sat_of(input logic [15:0] v);
        return (v > 16'd15) ? 32'd15 : 32'(v);
    endfunction

    initial begin
        //           eip        ib ld pb pr alias  ghr    pm  pred alias  ghr    br  mis
        vecs[0]  = '{E,          0, 1, 0, 0, 6'h00, 6'h00, 0, 0, 6'h38, 6'h00, 0,  0};
        vecs[1]  = '{E,          0, 1, 1, 1, 6'h38, 6'h00, 0, 0, 6'h38, 6'h00, 1,  0};
        vecs[2]  = '{E,          0, 1, 1, 1, 6'h38, 6'h00, 0, 1, 6'h38, 6'h00, 2,  0};
        vecs[3]  = '{E,          0, 1, 1, 1, 6'h38, 6'h00, 0, 1, 6'h38, 6'h00, 3,  0};
        vecs[4]  = '{E,          0, 1, 1, 1, 6'h38, 6'h00, 0, 1, 6'h38, 6'h00, 4,  0};
        vecs[5]  = '{E,          0, 1, 1, 1, 6'h38, 6'h00, 0, 1, 6'h38, 6'h00, 5,  0};
        vecs[6]  = '{E,          0, 1, 1, 1, 6'h38, 6'h00, 0, 1, 6'h38, 6'h00, 6,  0};
        vecs[7]  = '{E,          0, 1, 1, 1, 6'h38, 6'h00, 0, 1, 6'h38, 6'h00, 7,  0};
        vecs[8]  = '{E,          0, 1, 1, 0, 6'h38, 6'h00, 0, 1, 6'h38, 6'h00, 8,  0};
        vecs[9]  = '{E,          0, 1, 0, 0, 6'h00, 6'h00, 0, 1, 6'h38, 6'h00, 8,  0};
        vecs[10] = '{E,          0, 1, 1, 0, 6'h38, 6'h00, 0, 1, 6'h38, 6'h00, 9,  0};
        vecs[11] = '{E,          0, 1, 0, 0, 6'h00, 6'h00, 0, 0, 6'h38, 6'h00, 9,  0};
        vecs[12] = '{E,          0, 1, 1, 1, 6'h00, 6'h02, 1, 0, 6'h38, 6'h05, 10, 1};
        vecs[13] = '{E,          1, 1, 1, 1, 6'h01, 6'h2A, 1, 0, 6'h3D, 6'h15, 11, 2};
        vecs[14] = '{32'h15,     1, 1, 0, 0, 6'h00, 6'h00, 0, 1, 6'h00, 6'h2B, 11, 2};
        vecs[15] = '{32'h00,     1, 1, 0, 0, 6'h00, 6'h00, 0, 0, 6'h2B, 6'h16, 11, 2};
        vecs[16] = '{32'h00,     1, 0, 1, 1, 6'h16, 6'h00, 0, 0, 6'h16, 6'h16, 12, 2};
        vecs[17] = '{32'h00,     0, 1, 0, 0, 6'h00, 6'h00, 0, 1, 6'h16, 6'h16, 12, 2};
        vecs[18] = '{32'h00,     0, 1, 0, 1, 6'h16, 6'h3F, 1, 1, 6'h16, 6'h16, 12, 2};
        vecs[19] = '{32'h00,     0, 1, 1, 0, 6'h16, 6'h00, 0, 1, 6'h16, 6'h16, 13, 2};
        vecs[20] = '{32'h00,     0, 1, 0, 0, 6'h00, 6'h00, 0, 0, 6'h16, 6'h16, 13, 2};
        vecs[21] = '{32'h00,     1, 1, 1, 1, 6'h3F, 6'h3F, 0, 0, 6'h16, 6'h2C, 14, 2};

        // Reset with the fetch address parked on 0x12345678.
        drive(E, 0, 0, 0, 0, 6'h00, 6'h00, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset alias", 32'(BP_alias), 32'h38);
        check("reset pred", 32'(prediction), 32'd0);
        check("reset ghr", 32'(GBHR), 32'd0);
        check("reset perf_br", 32'(perf_br), 32'd0);
        check("reset perf_mis", 32'(perf_mispred), 32'd0);

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].eip, vecs[i].is_br, vecs[i].ld, vecs[i].p_br, vecs[i].p_res,
                  vecs[i].p_alias, vecs[i].p_ghr, vecs[i].p_mis);
            #1;
            check($sformatf("v%0d pred", i), 32'(prediction), 32'(vecs[i].exp_pred));
            check($sformatf("v%0d alias", i), 32'(BP_alias), 32'(vecs[i].exp_alias));
            @(posedge clk);
            #1;
            check($sformatf("v%0d ghr", i), 32'(GBHR), 32'(vecs[i].exp_ghr));
            check($sformatf("v%0d perf_br", i), 32'(perf_br), 32'(vecs[i].exp_br));
            check($sformatf("v%0d perf_mis", i), 32'(perf_mispred), 32'(vecs[i].exp_mis));
            check($sformatf("v%0d sat_br", i), 32'(s_perf_br), sat_of(vecs[i].exp_br));
        end

        // Sixteen mispredicted not-taken resolutions at entry 0x20:
        // narrow perf counters pin at 4'hF, entry 0x20 bottoms out at 0.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            drive(32'h0, 0, 1, 1, 0, 6'h20, 6'h00, 1);
            @(posedge clk);
            #1;
            if (k == 12) begin
                check("sat mis reaches max", 32'(s_perf_mispred), 32'hF);
                check("sat br at max", 32'(s_perf_br), 32'hF);
                check("wide mis counting", 32'(perf_mispred), 32'd15);
            end
        end
        check("sat mis holds", 32'(s_perf_mispred), 32'hF);
        check("sat br holds", 32'(s_perf_br), 32'hF);
        check("wide br count", 32'(perf_br), 32'd30);
        check("wide mis count", 32'(perf_mispred), 32'd18);
        check("recover ghr", 32'(GBHR), 32'h00);

        @(negedge clk);
        drive(32'h20, 0, 1, 0, 0, 6'h00, 6'h00, 0);
        #1;
        check("floor alias", 32'(BP_alias), 32'h20);
        check("floor pred", 32'(prediction), 32'd0);
        // One taken train from the floor must leave the counter at 1.
        drive(32'h20, 0, 1, 1, 1, 6'h20, 6'h00, 0);
        @(posedge clk);
        @(negedge clk);
        drive(32'h20, 0, 1, 0, 0, 6'h00, 6'h00, 0);
        #1;
        check("floor no wrap", 32'(prediction), 32'd0);

        // Reset asserted alongside a train and a recovery: both are dropped.
        @(negedge clk);
        reset = 1'b1;
        drive(E, 1, 1, 1, 1, 6'h38, 6'h3F, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(E, 0, 1, 0, 0, 6'h00, 6'h00, 0);
        #1;
        check("midrst ghr", 32'(GBHR), 32'd0);
        check("midrst perf_br", 32'(perf_br), 32'd0);
        check("midrst perf_mis", 32'(perf_mispred), 32'd0);
        check("midrst sat_br", 32'(s_perf_br), 32'd0);
        check("midrst sat_mis", 32'(s_perf_mispred), 32'd0);
        check("midrst alias 38", 32'(BP_alias), 32'h38);
        check("midrst pred 38", 32'(prediction), 32'd0);
        drive(32'h01, 0, 1, 0, 0, 6'h00, 6'h00, 0);
        #1;
        check("midrst pred 01", 32'(prediction), 32'd0);
        drive(32'h00, 0, 1, 0, 0, 6'h00, 6'h00, 0);
        #1;
        check("midrst pred 00", 32'(prediction), 32'd0);
        drive(32'h3F, 0, 1, 0, 0, 6'h00, 6'h00, 0);
        #1;
        check("midrst pred 3F", 32'(prediction), 32'd0);

        // A single taken train after reset flips entry 0x38 to taken (1 -> 2).
        drive(E, 0, 1, 1, 1, 6'h38, 6'h00, 0);
        @(posedge clk);
        @(negedge clk);
        drive(E, 0, 1, 0, 0, 6'h00, 6'h00, 0);
        #1;
        check("post rst train pred", 32'(prediction), 32'd1);
        check("post rst perf_br", 32'(perf_br), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
